unified_mem_arbiter: RTL and testbench

//  Shares one single-port memory bus between the core's instruction-fetch port and its load/store port.

---
 rtl/unified_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory bus between the fetch and load/store ports.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority over fetch.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [DW-1:0] i_rdata_o,
  input  logic          d_req_i,
  input  logic [3:0]    d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          m_req_o,
  output logic [AW-1:0] m_addr_o,
  output logic [3:0]    m_we_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_ack_i,
  input  logic [DW-1:0] m_rdata_i,
  output logic          err_o
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_DATA = 2'd2} owner_e;

  state_e        state_r, state_s;
  owner_e        owner_r, owner_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [AW-1:0] m_addr_r, m_addr_s;
  logic [3:0]    m_we_r, m_we_s;
  logic [DW-1:0] m_wdata_r, m_wdata_s;
  logic          m_req_r, m_req_s;
  logic          i_rvalid_r, i_rvalid_s, d_rvalid_r, d_rvalid_s, err_r, err_s;
  logic [DW-1:0] i_rdata_r, i_rdata_s, d_rdata_r, d_rdata_s;
  logic [DW-1:0] ret_data_s;
  logic          i_gnt_s, d_gnt_s, pick_d_s, done_s;

`ifdef ARB_RR_EN
  logic rr_data_r;  // 1: data wins the next tie

  // Tie-break pointer: after any grant the other port wins the next tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_data_r <= 1'b0;
    end else if (i_gnt_s) begin
      rr_data_r <= 1'b1;
    end else if (d_gnt_s) begin
      rr_data_r <= 1'b0;
    end else begin
      rr_data_r <= rr_data_r;
    end
  end

  assign pick_d_s = d_req_i && (!i_req_i || rr_data_r);
`else
  assign pick_d_s = d_req_i;
`endif

  // Arbitration, bus sequencing and completion
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    timer_s    = timer_r;
    m_addr_s   = m_addr_r;
    m_we_s     = m_we_r;
    m_wdata_s  = m_wdata_r;
    m_req_s    = 1'b0;
    i_gnt_s    = 1'b0;
    d_gnt_s    = 1'b0;
    i_rvalid_s = 1'b0;
    d_rvalid_s = 1'b0;
    err_s      = 1'b0;
    i_rdata_s  = i_rdata_r;
    d_rdata_s  = d_rdata_r;
    done_s     = 1'b0;
    ret_data_s = {DW{1'b0}};
    case (state_r)
      IDLE: begin
        // Grants are gated by reset so every output is quiet while rst_n_i is low
        if (rst_n_i && pick_d_s) begin
          d_gnt_s   = 1'b1;
          owner_s   = OWN_DATA;
          m_addr_s  = d_addr_i;
          m_we_s    = d_we_i;
          m_wdata_s = d_wdata_i;
          m_req_s   = 1'b1;
          timer_s   = {TW{1'b0}};
          state_s   = BUSY;
        end else if (rst_n_i && i_req_i) begin
          i_gnt_s   = 1'b1;
          owner_s   = OWN_FETCH;
          m_addr_s  = i_addr_i;
          m_we_s    = 4'b0000;
          m_wdata_s = {DW{1'b0}};
          m_req_s   = 1'b1;
          timer_s   = {TW{1'b0}};
          state_s   = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (m_ack_i) begin
          done_s     = 1'b1;
          ret_data_s = (m_we_r == 4'b0000) ? m_rdata_i : {DW{1'b0}};
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          done_s = 1'b1;
          err_s  = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1);
          m_req_s = 1'b1;
        end
        if (done_s) begin
          state_s = IDLE;
          owner_s = OWN_NONE;
          timer_s = {TW{1'b0}};
          if (owner_r == OWN_FETCH) begin
            i_rvalid_s = 1'b1;
            i_rdata_s  = ret_data_s;
          end else begin
            d_rvalid_s = 1'b1;
            d_rdata_s  = ret_data_s;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        owner_s = OWN_NONE;
        timer_s = {TW{1'b0}};
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      owner_r    <= OWN_NONE;
      timer_r    <= {TW{1'b0}};
      m_addr_r   <= {AW{1'b0}};
      m_we_r     <= 4'b0000;
      m_wdata_r  <= {DW{1'b0}};
      m_req_r    <= 1'b0;
      i_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      err_r      <= 1'b0;
      i_rdata_r  <= {DW{1'b0}};
      d_rdata_r  <= {DW{1'b0}};
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      timer_r    <= timer_s;
      m_addr_r   <= m_addr_s;
      m_we_r     <= m_we_s;
      m_wdata_r  <= m_wdata_s;
      m_req_r    <= m_req_s;
      i_rvalid_r <= i_rvalid_s;
      d_rvalid_r <= d_rvalid_s;
      err_r      <= err_s;
      i_rdata_r  <= i_rdata_s;
      d_rdata_r  <= d_rdata_s;
    end
  end

  assign i_gnt_o    = i_gnt_s;
  assign d_gnt_o    = d_gnt_s;
  assign i_rvalid_o = i_rvalid_r;
  assign d_rvalid_o = d_rvalid_r;
  assign i_rdata_o  = i_rdata_r;
  assign d_rdata_o  = d_rdata_r;
  assign m_req_o    = m_req_r;
  assign m_addr_o   = m_addr_r;
  assign m_we_o     = m_we_r;
  assign m_wdata_o  = m_wdata_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level timing model.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          i_req_i, i_gnt_o, i_rvalid_o;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_rdata_o;
  logic          d_req_i, d_gnt_o, d_rvalid_o;
  logic [3:0]    d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic          m_req_o, m_ack_i, err_o;
  logic [AW-1:0] m_addr_o;
  logic [3:0]    m_we_o;
  logic [DW-1:0] m_wdata_o, m_rdata_i;

  always #5 clk_i = ~clk_i;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: one transaction in flight, described by its grant/ack/return cycles
  int            busy_until, gnt_cyc, ack_cyc, ret_cyc, ret_owner, txn_owner, force_lat;
  logic [DW-1:0] ret_data, exp_i_rdata, exp_d_rdata, ack_data, force_data, txn_wdata;
  logic [AW-1:0] txn_addr;
  logic [3:0]    txn_we;
  logic          ret_err, rr_pref_data, i_gnt_seen, d_gnt_seen;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_req_cycles;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero();
    check_bit("rst_i_gnt", i_gnt_o, 1'b0);
    check_bit("rst_i_rvalid", i_rvalid_o, 1'b0);
    check("rst_i_rdata", i_rdata_o, 32'h0);
    check_bit("rst_d_gnt", d_gnt_o, 1'b0);
    check_bit("rst_d_rvalid", d_rvalid_o, 1'b0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    check_bit("rst_m_req", m_req_o, 1'b0);
    check("rst_m_addr", m_addr_o, 32'h0);
    check("rst_m_we", {28'd0, m_we_o}, 32'h0);
    check("rst_m_wdata", m_wdata_o, 32'h0);
    check_bit("rst_err", err_o, 1'b0);
  endtask

  task automatic reset_model();
    busy_until = 0; gnt_cyc = -100; ack_cyc = -1; ret_cyc = -1; ret_owner = 0; txn_owner = 0;
    ret_err = 1'b0; ret_data = 32'h0; exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
    rr_pref_data = 1'b0; force_lat = -1; i_gnt_seen = 1'b0; d_gnt_seen = 1'b0;
  endtask

  // Advance one cycle; requesters drop a granted request and optionally raise new ones
  task automatic step_begin(input bit rand_en);
    @(posedge clk_i); cyc++; #1;
    if (i_gnt_seen) i_req_i = 1'b0;
    if (d_gnt_seen) d_req_i = 1'b0;
    i_gnt_seen = 1'b0; d_gnt_seen = 1'b0;
    if (rand_en && !i_req_i && $urandom_range(0, 2) == 0) begin
      i_req_i = 1'b1; i_addr_i = $urandom;
    end
    if (rand_en && !d_req_i && $urandom_range(0, 2) == 0) begin
      d_req_i = 1'b1; d_addr_i = $urandom; d_wdata_i = $urandom;
      d_we_i = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    end
  endtask

  // Drive the memory side, compare every output, then let the model take any grant
  task automatic step_end();
    int   win, lat;
    logic exp_mreq, ret_now;
    if (ack_cyc == cyc) begin m_ack_i = 1'b1; m_rdata_i = ack_data; end
    else begin m_ack_i = 1'b0; m_rdata_i = $urandom; end
    #1;
    ret_now = (ret_cyc == cyc);
    if (ret_now && ret_owner == 1) exp_i_rdata = ret_data;
    if (ret_now && ret_owner == 2) exp_d_rdata = ret_data;
    check_bit("i_rvalid", i_rvalid_o, ret_now && ret_owner == 1);
    check_bit("d_rvalid", d_rvalid_o, ret_now && ret_owner == 2);
    check_bit("err", err_o, ret_now && ret_err);
    check("i_rdata", i_rdata_o, exp_i_rdata);
    check("d_rdata", d_rdata_o, exp_d_rdata);
    exp_mreq = (cyc > gnt_cyc) && (cyc < busy_until);
    check_bit("m_req", m_req_o, exp_mreq);
    if (exp_mreq) begin
      check("m_addr", m_addr_o, txn_addr);
      check("m_we", {28'd0, m_we_o}, {28'd0, txn_we});
      if (txn_owner == 2) check("m_wdata", m_wdata_o, txn_wdata);
    end
    win = 0;
    if (cyc >= busy_until) begin
      if (d_req_i && i_req_i) begin
`ifdef ARB_RR_EN
        win = rr_pref_data ? 2 : 1;
`else
        win = 2;
`endif
      end else if (d_req_i) win = 2;
      else if (i_req_i) win = 1;
    end
    check_bit("i_gnt", i_gnt_o, win == 1);
    check_bit("d_gnt", d_gnt_o, win == 2);
    i_gnt_seen = i_gnt_o; d_gnt_seen = d_gnt_o;
    if (win != 0) begin
      txn_owner = win;
      txn_addr  = (win == 2) ? d_addr_i : i_addr_i;
      txn_we    = (win == 2) ? d_we_i : 4'b0000;
      txn_wdata = d_wdata_i;
      rr_pref_data = (win == 1);
      if (force_lat >= 0) begin
        lat = force_lat; ack_data = force_data; force_lat = -1;
      end else begin
        lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 1)) : int'($urandom_range(0, 2));
        ack_data = $urandom;
      end
      gnt_cyc = cyc; ret_owner = win;
      if (lat <= TIMEOUT - 1) begin
        ack_cyc = cyc + 1 + lat; ret_cyc = ack_cyc + 1; ret_err = 1'b0;
        ret_data = (txn_we != 4'b0000) ? 32'h0 : ack_data;
      end else begin
        ack_cyc = -1; ret_cyc = cyc + TIMEOUT + 1; ret_err = 1'b1; ret_data = 32'h0;
      end
      busy_until = ret_cyc;
    end
  endtask

  task automatic run_cycles(input int n, input bit rand_en);
    for (int k = 0; k < n; k++) begin
      step_begin(rand_en);
      step_end();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 32'h10,  32'h0,    0,  32'h13,        32'h13,        1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 4'b0011, 32'h200, 32'hA5A5, 2,  32'hDEAD_BEEF, 32'h0,         1'b0, 3};
    vecs[2] = '{1'b0, 1'b1, 4'b0000, 32'h44,  32'h0,    1,  32'h1234_5678, 32'h1234_5678, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b1, 4'b0000, 32'h300, 32'h0,    99, 32'hFFFF_FFFF, 32'h0,         1'b1, 16};
    vecs[4] = '{1'b1, 1'b0, 4'b0000, 32'h20,  32'h0,    0,  32'h55,        32'h55,        1'b0, 1};
    vecs[5] = '{1'b0, 1'b1, 4'b0000, 32'h48,  32'h0,    15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 16};
    vecs[6] = '{1'b1, 1'b0, 4'b0000, 32'h24,  32'h0,    16, 32'h77,        32'h0,         1'b1, 16};

    rst_n_i = 1'b0; i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h4; d_addr_i = 32'h8;
    d_we_i = 4'hF; d_wdata_i = 32'h1234; m_ack_i = 1'b1; m_rdata_i = 32'hFFFF_FFFF;
    reset_model();
    #3;
    check_all_zero();
    i_req_i = 1'b0; d_req_i = 1'b0; m_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_n_i = 1'b1;
    step_end();

    foreach (vecs[v]) begin
      int n_req;
      bit got;
      step_begin(1'b0);
      i_req_i = vecs[v].i_req; i_addr_i = vecs[v].addr;
      d_req_i = vecs[v].d_req; d_addr_i = vecs[v].addr;
      d_we_i = vecs[v].we; d_wdata_i = vecs[v].wdata;
      force_lat = vecs[v].lat; force_data = vecs[v].mdata;
      step_end();
      check_bit("vec_i_gnt", i_gnt_o, vecs[v].i_req);
      check_bit("vec_d_gnt", d_gnt_o, vecs[v].d_req);
      n_req = 0; got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
        step_begin(1'b0);
        step_end();
        if (m_req_o) n_req++;
        if (i_rvalid_o || d_rvalid_o) begin
          got = 1'b1;
          check("vec_latency", k, vecs[v].exp_req_cycles + 1);
          check("vec_rdata", vecs[v].i_req ? i_rdata_o : d_rdata_o, vecs[v].exp_rdata);
          check_bit("vec_err", err_o, vecs[v].exp_err);
          check_bit("vec_owner", i_rvalid_o, vecs[v].i_req);
        end
      end
      check_bit("vec_done", got, 1'b1);
      check("vec_req_cycles", n_req, vecs[v].exp_req_cycles);
    end

    // Simultaneous requests after a fetch was served last: data goes first,
    // fetch is granted in the data's rvalid cycle
    step_begin(1'b0);
    i_req_i = 1'b1; i_addr_i = 32'h80; d_req_i = 1'b1; d_addr_i = 32'h84; d_we_i = 4'b0000;
    force_lat = 0; force_data = 32'h1111;
    step_end();
    check_bit("both_d_first", d_gnt_o, 1'b1);
    run_cycles(2, 1'b0);
    check_bit("both_d_rvalid", d_rvalid_o, 1'b1);
    check_bit("both_i_gnt_in_rvalid", i_gnt_o, 1'b1);
    run_cycles(40, 1'b0);

    // Data served last, then both again
    step_begin(1'b0);
    d_req_i = 1'b1; d_addr_i = 32'h88; d_we_i = 4'b0000;
    step_end();
    check_bit("solo_d_gnt", d_gnt_o, 1'b1);
    run_cycles(40, 1'b0);
    step_begin(1'b0);
    i_req_i = 1'b1; i_addr_i = 32'h90; d_req_i = 1'b1; d_addr_i = 32'h94; d_we_i = 4'b0000;
    step_end();
`ifdef ARB_RR_EN
    check_bit("repeat_i_first", i_gnt_o, 1'b1);
`else
    check_bit("repeat_d_first", d_gnt_o, 1'b1);
`endif
    run_cycles(60, 1'b0);

    run_cycles(3000, 1'b1);
    run_cycles(80, 1'b0);

    // Reset while a transaction is on the bus: it must vanish without an rvalid
    step_begin(1'b0);
    d_req_i = 1'b1; d_addr_i = 32'h400; d_we_i = 4'b0000; force_lat = 99;
    step_end();
    run_cycles(3, 1'b0);
    @(posedge clk_i); cyc++; #1;
    i_req_i = 1'b1; i_addr_i = 32'h500; m_ack_i = 1'b0; rst_n_i = 1'b0;
    #1;
    check_all_zero();
    repeat (2) begin @(posedge clk_i); cyc++; end
    #1; rst_n_i = 1'b1;
    reset_model();
    step_end();
    run_cycles(40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
